// File: rtl/fetch_controller_pkg.sv
// Shared widths, state encoding and queue entry type for the fetch controller.
package fetch_controller_pkg;

   localparam int unsigned ADDR_WIDTH       = 16;
   localparam int unsigned INST_WIDTH       = 32;
   localparam int unsigned FQ_DEPTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StHalted = 2'd2
   } fc_state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Control, instruction-memory and decode-side signals of the fetch controller.
interface fetch_controller_if;
   import fetch_controller_pkg::*;

   logic                  start;
   logic                  halt;
   logic                  redirect_valid;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [INST_WIDTH-1:0] imem_inst0;
   logic [INST_WIDTH-1:0] imem_inst1;
   logic                  out0_valid;
   logic                  out1_valid;
   logic [INST_WIDTH-1:0] out0_inst;
   logic [INST_WIDTH-1:0] out1_inst;
   logic [ADDR_WIDTH-1:0] out0_pc;
   logic [ADDR_WIDTH-1:0] out1_pc;
   logic [1:0]            take;
   logic                  busy;

   // Core / memory / decode side.
   modport master (
      output start, halt, redirect_valid, redirect_pc, imem_inst0, imem_inst1, take,
      input  imem_addr, out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc, busy
   );

   // Fetch controller side.
   modport slave (
      input  start, halt, redirect_valid, redirect_pc, imem_inst0, imem_inst1, take,
      output imem_addr, out0_valid, out1_valid, out0_inst, out1_inst, out0_pc, out1_pc, busy
   );

endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of {pc, inst}: up to two pushes and two pops per cycle.
module fetch_queue
   import fetch_controller_pkg::*;
#(
   parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_flush,
   input  logic [1:0]    i_push_cnt,
   input  fq_entry_t     i_push0,
   input  fq_entry_t     i_push1,
   input  logic [1:0]    i_take,
   output logic [CW-1:0] o_count,
   output logic          o_valid0,
   output logic          o_valid1,
   output fq_entry_t     o_head0,
   output fq_entry_t     o_head1
);

   fq_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic [1:0]    w_avail;
   logic [1:0]    w_take_eff;
   logic [PW-1:0] w_head1;

   // Clamp the requested pop to the number of entries actually presented.
   always_comb begin
      w_avail    = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
      w_take_eff = (i_take > w_avail) ? w_avail : i_take;
      w_head1    = r_head + PW'(1);
   end

   // Entry storage; not reset, validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (!i_flush) begin
         if (i_push_cnt != 2'd0) r_mem[r_tail] <= i_push0;
         if (i_push_cnt == 2'd2) r_mem[r_tail + PW'(1)] <= i_push1;
      end
   end

   // Pointer and occupancy update; a flush drops this cycle's push and pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + PW'(w_take_eff);
         r_tail  <= r_tail + PW'(i_push_cnt);
         r_count <= r_count + CW'(i_push_cnt) - CW'(w_take_eff);
      end
   end

   // Head views; invalid slots drive zero.
   always_comb begin
      o_count  = r_count;
      o_valid0 = (r_count != '0);
      o_valid1 = (r_count > CW'(1));
      o_head0  = o_valid0 ? r_mem[r_head] : '0;
      o_head1  = o_valid1 ? r_mem[w_head1] : '0;
   end

endmodule

// File: rtl/fetch_controller.sv
// Fetch state machine and pc: fills the fetch queue two words per cycle from a dual-read imem.
module fetch_controller
   import fetch_controller_pkg::*;
#(
   parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   fetch_controller_if.slave  bus
);

   localparam int unsigned CW = $clog2(FQ_DEPTH + 1);

   fc_state_e             r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [CW-1:0]         w_count;
   logic [CW-1:0]         w_free;
   logic                  w_flush;
   logic                  w_fetch;
   logic [1:0]            w_push_cnt;
   fq_entry_t             w_push0;
   fq_entry_t             w_push1;
   fq_entry_t             w_head0;
   fq_entry_t             w_head1;
   logic                  w_valid0;
   logic                  w_valid1;

   // Redirect beats halt, halt beats fetch; fetch size follows free space before the pop.
   always_comb begin
      w_flush      = bus.redirect_valid && (r_state != StIdle);
      w_fetch      = (r_state == StRun) && !bus.redirect_valid && !bus.halt;
      w_free       = CW'(FQ_DEPTH) - w_count;
      w_push_cnt   = 2'd0;
      if (w_fetch) begin
         if (w_free >= CW'(2))      w_push_cnt = 2'd2;
         else if (w_free == CW'(1)) w_push_cnt = 2'd1;
      end
      w_push0.pc   = r_pc;
      w_push0.inst = bus.imem_inst0;
      w_push1.pc   = r_pc + ADDR_WIDTH'(1);
      w_push1.inst = bus.imem_inst1;
   end

   // State and pc; pc advances by the number of words pushed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_pc    <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (bus.start) r_state <= StRun;
            end
            StRun: begin
               if (bus.redirect_valid) begin
                  r_pc <= bus.redirect_pc;
               end else if (bus.halt) begin
                  r_state <= StHalted;
               end else begin
                  r_pc <= r_pc + ADDR_WIDTH'(w_push_cnt);
               end
            end
            StHalted: begin
               if (bus.redirect_valid) begin
                  r_state <= StRun;
                  r_pc    <= bus.redirect_pc;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (w_flush),
      .i_push_cnt (w_push_cnt),
      .i_push0    (w_push0),
      .i_push1    (w_push1),
      .i_take     (bus.take),
      .o_count    (w_count),
      .o_valid0   (w_valid0),
      .o_valid1   (w_valid1),
      .o_head0    (w_head0),
      .o_head1    (w_head1)
   );

   // Outputs come straight from registered state.
   always_comb begin
      bus.imem_addr  = r_pc;
      bus.busy       = (r_state == StRun);
      bus.out0_valid = w_valid0;
      bus.out1_valid = w_valid1;
      bus.out0_inst  = w_head0.inst;
      bus.out1_inst  = w_head1.inst;
      bus.out0_pc    = w_head0.pc;
      bus.out1_pc    = w_head1.pc;
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a queue-level reference model.
module tb_fetch_controller;

   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] pc;
      logic [31:0] inst;
   } m_ent_t;

   logic clk;
   logic reset;

   fetch_controller_if u_if ();

   fetch_controller #(
      .FQ_DEPTH (DEPTH)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   m_ent_t      m_q[$];
   logic [15:0] m_pc    = '0;
   int          m_state = 0;   // 0 idle, 1 run, 2 halted

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return {16'h0, a} + 32'h100;
   endfunction

   // Instruction memory: word k holds k + 0x100.
   always_comb begin
      logic [15:0] a1;
      a1             = u_if.imem_addr + 16'd1;
      u_if.imem_inst0 = mem_word(u_if.imem_addr);
      u_if.imem_inst1 = mem_word(a1);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_pop(input int n);
      repeat (n) void'(m_q.pop_front());
   endtask

   task automatic model_step();
      int nv;
      int eff;
      int free;
      int n;
      nv  = (m_q.size() > 2) ? 2 : m_q.size();
      eff = (int'(u_if.take) > nv) ? nv : int'(u_if.take);
      case (m_state)
         0: begin
            model_pop(eff);
            if (u_if.start) m_state = 1;
         end
         1: begin
            if (u_if.redirect_valid) begin
               m_q.delete();
               m_pc = u_if.redirect_pc;
            end else if (u_if.halt) begin
               model_pop(eff);
               m_state = 2;
            end else begin
               free = DEPTH - m_q.size();
               n    = (free > 2) ? 2 : free;
               model_pop(eff);
               for (int k = 0; k < n; k++) begin
                  m_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
                  m_pc = m_pc + 16'd1;
               end
            end
         end
         default: begin
            if (u_if.redirect_valid) begin
               m_q.delete();
               m_pc    = u_if.redirect_pc;
               m_state = 1;
            end else begin
               model_pop(eff);
            end
         end
      endcase
   endtask

   // Model advances on each edge, or clears on reset.
   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_q.delete();
            m_pc    = '0;
            m_state = 0;
         end else begin
            model_step();
         end
      end
   end

   // Compare all outputs against the model every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         chk("busy",       u_if.busy,       m_state == 1);
         chk("imem_addr",  u_if.imem_addr,  m_pc);
         chk("out0_valid", u_if.out0_valid, m_q.size() > 0);
         chk("out1_valid", u_if.out1_valid, m_q.size() > 1);
         chk("out0_inst",  u_if.out0_inst,  (m_q.size() > 0) ? m_q[0].inst : 32'h0);
         chk("out0_pc",    u_if.out0_pc,    (m_q.size() > 0) ? m_q[0].pc : 16'h0);
         chk("out1_inst",  u_if.out1_inst,  (m_q.size() > 1) ? m_q[1].inst : 32'h0);
         chk("out1_pc",    u_if.out1_pc,    (m_q.size() > 1) ? m_q[1].pc : 16'h0);
      end
   end

   task automatic step(input logic s, input logic h, input logic r, input logic [15:0] rp,
                       input logic [1:0] tk);
      u_if.start          = s;
      u_if.halt           = h;
      u_if.redirect_valid = r;
      u_if.redirect_pc    = rp;
      u_if.take           = tk;
      @(negedge clk);
   endtask

   initial begin
      reset               = 1'b1;
      u_if.start          = 1'b0;
      u_if.halt           = 1'b0;
      u_if.redirect_valid = 1'b0;
      u_if.redirect_pc    = '0;
      u_if.take           = '0;
      @(negedge clk);
      @(negedge clk);
      chk("lit_rst_busy", u_if.busy, 0);
      chk("lit_rst_addr", u_if.imem_addr, 0);
      chk("lit_rst_v0",   u_if.out0_valid, 0);
      chk("lit_rst_i0",   u_if.out0_inst, 0);
      #2 reset = 1'b0;

      // Redirect in IDLE is ignored.
      step(0, 0, 1, 16'h40, 0);
      chk("lit_idle_redir_addr", u_if.imem_addr, 0);
      chk("lit_idle_redir_busy", u_if.busy, 0);

      // Start, then fill the queue with take=0.
      step(1, 0, 0, 0, 0);
      chk("lit_start_busy", u_if.busy, 1);
      chk("lit_start_v0",   u_if.out0_valid, 0);
      step(0, 0, 0, 0, 0);
      chk("lit_f1_i0",   u_if.out0_inst, 32'h100);
      chk("lit_f1_pc0",  u_if.out0_pc, 0);
      chk("lit_f1_i1",   u_if.out1_inst, 32'h101);
      chk("lit_f1_pc1",  u_if.out1_pc, 1);
      chk("lit_f1_addr", u_if.imem_addr, 2);
      step(0, 0, 0, 0, 0);
      chk("lit_f2_addr", u_if.imem_addr, 4);
      step(0, 0, 0, 0, 0);
      chk("lit_full_addr", u_if.imem_addr, 4);
      chk("lit_full_pc0",  u_if.out0_pc, 0);

      // Redirect with take=2 on a full queue.
      step(0, 0, 1, 16'h40, 2);
      chk("lit_redir_v0",   u_if.out0_valid, 0);
      chk("lit_redir_addr", u_if.imem_addr, 16'h40);
      step(0, 0, 0, 0, 0);
      chk("lit_redir_pc0", u_if.out0_pc, 16'h40);
      chk("lit_redir_i0",  u_if.out0_inst, 32'h140);
      step(0, 0, 0, 0, 0);

      // Count 3 then a single-word fetch.
      step(0, 0, 0, 0, 1);
      chk("lit_c3_pc0",  u_if.out0_pc, 16'h41);
      chk("lit_c3_addr", u_if.imem_addr, 16'h44);
      step(0, 0, 0, 0, 0);
      chk("lit_single_addr", u_if.imem_addr, 16'h45);
      chk("lit_single_pc1",  u_if.out1_pc, 16'h42);

      // Halt and drain one per cycle, then redirect resumes.
      step(0, 1, 0, 0, 1);
      chk("lit_halt_busy", u_if.busy, 0);
      chk("lit_halt_pc0",  u_if.out0_pc, 16'h42);
      repeat (3) step(0, 0, 0, 0, 1);
      chk("lit_drain_v0",   u_if.out0_valid, 0);
      chk("lit_drain_addr", u_if.imem_addr, 16'h45);
      step(0, 0, 1, 16'h10, 0);
      chk("lit_resume_busy", u_if.busy, 1);
      chk("lit_resume_addr", u_if.imem_addr, 16'h10);
      step(0, 0, 0, 0, 0);
      chk("lit_resume_pc0", u_if.out0_pc, 16'h10);
      chk("lit_resume_i1",  u_if.out1_inst, 32'h111);

      // Asynchronous reset mid-operation.
      #2 reset = 1'b1;
      #1;
      chk("lit_arst_v0",   u_if.out0_valid, 0);
      chk("lit_arst_busy", u_if.busy, 0);
      chk("lit_arst_addr", u_if.imem_addr, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      step(0, 0, 0, 0, 0);
      chk("lit_nostart_busy", u_if.busy, 0);
      chk("lit_nostart_v0",   u_if.out0_valid, 0);

      // Steady take=2 streams pcs in order.
      step(1, 0, 0, 0, 2);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 2);
         chk("lit_stream_pc0", u_if.out0_pc, 64'(2 * k));
         chk("lit_stream_pc1", u_if.out1_pc, 64'(2 * k + 1));
         chk("lit_stream_v1",  u_if.out1_valid, 1);
      end

      // Over-take on a single entry, then pc wrap at 0xFFFF.
      step(0, 1, 0, 0, 1);
      chk("lit_one_pc0", u_if.out0_pc, 5);
      chk("lit_one_v1",  u_if.out1_valid, 0);
      step(0, 0, 0, 0, 2);
      chk("lit_under_v0", u_if.out0_valid, 0);
      step(0, 0, 0, 0, 2);
      chk("lit_under2_v0", u_if.out0_valid, 0);
      step(0, 0, 1, 16'hFFFF, 0);
      chk("lit_wrap_addr0", u_if.imem_addr, 16'hFFFF);
      step(0, 0, 0, 0, 0);
      chk("lit_wrap_pc0",  u_if.out0_pc, 16'hFFFF);
      chk("lit_wrap_i0",   u_if.out0_inst, 32'h100FF);
      chk("lit_wrap_pc1",  u_if.out1_pc, 16'h0000);
      chk("lit_wrap_i1",   u_if.out1_inst, 32'h100);
      chk("lit_wrap_addr", u_if.imem_addr, 16'h0001);
      repeat (3) step(0, 0, 0, 0, 2);
      chk("lit_tail_pc0", u_if.out0_pc, 16'h0005);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameters (name, default, meaning): FQ_DEPTH, 4, fetch-queue entries (power of two, >=2); widths are the shared `ADDR_WIDTH / `INST_WIDTH macros.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  leave IDLE and begin fetching at current pc.
REQ-005 halt  input  1  stop issuing fetches (enter HALTED).
REQ-006 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc  input  `ADDR_WIDTH  redirect target.
REQ-008 imem_addr  output  `ADDR_WIDTH  address to the dual-read instruction memory (returns pc, pc+1 combinationally).
REQ-009 imem_inst0 / imem_inst1  input  `INST_WIDTH each  memory words at imem_addr and imem_addr+1.
REQ-010 out0_valid, out1_valid  output  1 each  queue head / head+1 hold valid instructions.
REQ-011 out0_inst, out1_inst  output  `INST_WIDTH each  head and head+1 instructions.
REQ-012 out0_pc, out1_pc  output  `ADDR_WIDTH each  addresses of those instructions.
REQ-013 take  input  2  number of instructions decode consumes this cycle (0..2).
REQ-014 busy  output  1  state is RUN.

Function
REQ-015 States: IDLE, RUN, HALTED; encoding 2 bits.
REQ-016 IDLE->RUN on start; RUN->HALTED on halt; HALTED->RUN on redirect_valid; any state->IDLE only by reset.
REQ-017 redirect_valid in IDLE is ignored; in RUN or HALTED: queue emptied, pc <= redirect_pc, state RUN, same-cycle take and fetch discarded.
REQ-018 redirect_valid has priority over halt; halt has priority over fetch in the same cycle.
REQ-019 imem_addr = pc at all times (combinational from pc register).
REQ-020 Fetch in RUN only: free = FQ_DEPTH - count (count before this cycle's pop); free>=2 -> push imem_inst0, imem_inst1 with pcs pc, pc+1, pc <= pc+2; free==1 -> push imem_inst0 only, pc <= pc+1; free==0 -> no push, pc holds.
REQ-021 Pop: effective_take = min(take, number of valid outputs); excess take is ignored, never underflows.
REQ-022 Push and pop in the same cycle both take effect; count_next = count + pushed - effective_take.
REQ-023 out0 = queue head, out1 = head+1; outN_valid = count > N; invalid outputs drive 0.
REQ-024 pc arithmetic wraps modulo 2^`ADDR_WIDTH; queue pointers wrap modulo FQ_DEPTH.
REQ-025 Fetch-to-output latency: instruction fetched in cycle N appears on out0/out1 in cycle N+1.
REQ-026 HALTED: no pushes; pops continue, draining the queue.
REQ-027 busy = 1 exactly when state is RUN.

Reset
REQ-028 Reset asserted (asynchronously): state IDLE, pc 0, queue empty (count, head, tail 0), all outN_valid 0, all out data 0, busy 0.
REQ-029 Reset mid-operation discards all queued instructions; first fetch after release requires start.
REQ-030 Queue storage arrays need not be reset; only pointers and count.

Structure
REQ-031 State encodings, FQ_DEPTH default and the `ADDR_WIDTH/`INST_WIDTH macros live in the shared defines include.
REQ-032 One sub-module: fetch_queue (2-wide push, 2-wide pop circular buffer of {pc, inst}); state machine and pc logic in fetch_controller.

Verification
REQ-033 Reset, start, take=0, memory word k = k+0x100 -> cycle1 out0=0x100/pc0, out1=0x101/pc1; cycle2 count 4, pc=4; fetch stops, pc held at 4.
REQ-034 Queue count 3, take=0 -> single push of word at pc, pc+1 only; count 4.
REQ-035 Steady take=2 from start -> two instructions per cycle, pcs 0,1,2,3,4,5 in order, no gaps after first cycle.
REQ-036 Queue holds 4, redirect_valid with redirect_pc=0x40 and take=2 same cycle -> next cycle queue empty, pc=0x40; following cycle out0_pc=0x40.
REQ-037 halt with 4 queued, take=1 per cycle -> four instructions drained, no new pushes, busy=0; then redirect to 0x10 -> RUN, fetch resumes at 0x10.
REQ-038 take=2 with count 1 -> one pop, count 0, no underflow; pc at 0xFFFF (16-bit) wraps to 0x0000/0x0001.
